iecdrv_rom_arb: RTL and testbench
=================================

IECDRV_ROM_ARB -- requirements
Module: iecdrv_rom_arb

Interface
REQ-001 SHALL have parameter NDR, default 4, number of drive ports, legal 1..8.
REQ-002 SHALL have parameter RD_LAT, default 2, shared-memory read latency in clocks from mem_addr change to valid mem_q, legal 1..3.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ph2_f  in  1  one-clock frame-start strobe.
REQ-006 SHALL have port stdrom  in  1  1 = standard 16K ROM selected; forces address bit 13 through.
REQ-007 SHALL have port drv_addr  in  NDR*15  packed drive ROM addresses; drive i is at bits [15i+14:15i].
REQ-008 SHALL have port drv_data  out  NDR*8  packed per-drive captured ROM bytes.
REQ-009 SHALL have port drv_valid  out  NDR  one-clock pulse per drive when its byte is updated.
REQ-010 SHALL have port frame_done  out  1  one-clock pulse when a complete frame ends.
REQ-011 SHALL have port mem_addr  out  15  registered address to the shared ROM.
REQ-012 SHALL have port mem_q  in  8  shared ROM read data.
REQ-013 SHALL have port rom_wr  in  1  ROM load write strobe, already synchronous to clk.
REQ-014 SHALL have port rom_waddr  in  15  ROM load address.
REQ-015 SHALL have port rom_wdata  in  8  ROM load data.
REQ-016 SHALL have port rom_sz  out  2  detected ROM size: 00 = 8K, 01 = 16K, 11 = 32K.
REQ-017 SHALL have port empty8k  out  1  1 = the lower 8K of a 32K image holds only fill bytes.

Function
REQ-018 SHALL hold a slot counter st of width clog2(NDR+RD_LAT+2); ph2_f sets st=0; otherwise st increments until it reaches IDLE = NDR+RD_LAT+1 and then holds.
REQ-019 SHALL, in each cycle with st=s<NDR, register mem_addr = {a[14]&rom_sz[1], a[13]&(rom_sz[0]|stdrom), a[12:0]}, where a is drive s's address.
REQ-020 SHALL, in each cycle with st=s+1+RD_LAT for s<NDR, capture mem_q into the drv_data byte of drive s and pulse drv_valid[s] in the next clock.
REQ-021 SHALL pulse frame_done one clock after st first reaches IDLE in a frame; it SHALL NOT re-pulse while st holds at IDLE.
REQ-022 SHALL leave mem_addr unchanged while st>=NDR.
REQ-023 A ph2_f arriving before IDLE SHALL abort the frame: drives not yet captured keep their old drv_data, get no drv_valid pulse, and get no frame_done pulse; the new frame then starts at st=0.
REQ-024 ph2_f arriving in the same clock as a capture slot SHALL take priority; that capture SHALL NOT occur.
REQ-025 drv_data for a drive SHALL change only in its own capture slot.
REQ-026 SHALL maintain flags b32 and b16, with rom_sz = {b32, b32|b16}, updated as follows:
- rom_wr with rom_wdata not equal to 00 and not equal to FF: {b32,b16} <= rom_waddr[14:13].
- rom_wr with rom_waddr=0: empty8k <= 1.
- rom_wr with non-fill data, rom_waddr[14:8] != 0 and rom_waddr[14:13] = 0: empty8k <= 0. This clear SHALL win over the address-0 set in the same clock. (Address 0 cannot satisfy both conditions.)
REQ-027 rom_sz and empty8k SHALL be registered; mem_addr masking SHALL use the registered rom_sz.
REQ-028 Frame length is NDR+RD_LAT+2 clocks; the integrator SHALL space ph2_f by at least that many clocks; shorter spacing is handled as an abort per REQ-023.

Reset
REQ-029 On reset: st=IDLE, mem_addr=0, all drv_data=FF, drv_valid=0, frame_done=0, b32=b16=1 (rom_sz=11), empty8k=1.
REQ-030 Reset asserted mid-frame SHALL cancel all pending captures; after deassertion there is no activity until the next ph2_f.
REQ-031 Reset SHALL override ph2_f and rom_wr in the same clock.

Verification
REQ-032 NDR=4, RD_LAT=2, rom_sz=11, model ROM q = addr[7:0], drive addresses 0x10, 0x21, 0x32, 0x43; single ph2_f -> drv_valid pulses at clocks 4, 5, 6, 7 after ph2_f with bytes 10, 21, 32, 43, and frame_done at clock 8.
REQ-033 Write 0x55 at ROM address 0x2000, then write 0x00 at 0x6000 -> rom_sz=01 with the 0x6000 write ignored; drive address 0x6ABC -> mem_addr=0x2ABC; with stdrom=1 and rom_sz=00 -> mem_addr=0x2ABC.
REQ-034 Write at address 0 (data 0x12), then 0x34 at 0x0100, then 0xFF at 0x0200 -> empty8k sequence is 1, 0, 0.
REQ-035 Second ph2_f 3 clocks after the first (NDR=4, RD_LAT=2) -> no drv_valid and no frame_done; the next full frame updates all four bytes.
REQ-036 Reset asserted at st=5 -> drv_data all FF, no further drv_valid pulses; NDR=1, RD_LAT=1 frame -> drv_valid[0] at clock 3 after ph2_f and frame_done at clock 4.

Source files
------------

// File: rtl/iecdrv_rom_arb_if.sv
// Bundle of frame strobe, drive ROM ports, shared-ROM bus and ROM-load signals
// for the drive ROM arbiter.
interface iecdrv_rom_arb_if #(
    parameter int unsigned NDR = 4
);
    logic                 ph2_f;
    logic                 stdrom;
    logic [NDR*15-1:0]    drv_addr;
    logic [NDR*8-1:0]     drv_data;
    logic [NDR-1:0]       drv_valid;
    logic                 frame_done;
    logic [14:0]          mem_addr;
    logic [7:0]           mem_q;
    logic                 rom_wr;
    logic [14:0]          rom_waddr;
    logic [7:0]           rom_wdata;
    logic [1:0]           rom_sz;
    logic                 empty8k;

    // arbiter side
    modport slave (
        input  ph2_f, stdrom, drv_addr, mem_q, rom_wr, rom_waddr, rom_wdata,
        output drv_data, drv_valid, frame_done, mem_addr, rom_sz, empty8k
    );

    // drive / memory / loader side
    modport master (
        output ph2_f, stdrom, drv_addr, mem_q, rom_wr, rom_waddr, rom_wdata,
        input  drv_data, drv_valid, frame_done, mem_addr, rom_sz, empty8k
    );
endinterface

// File: rtl/iecdrv_rom_arb.sv
// Time-slot arbiter sharing one drive ROM between NDR drives: one address slot
// per drive each frame, read data captured RD_LAT+1 slots later.
module iecdrv_rom_arb #(
    parameter int unsigned NDR    = 4,
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    iecdrv_rom_arb_if.slave bus
);
    localparam int unsigned IDLE_V = NDR + RD_LAT + 1;
    localparam int unsigned ST_W   = $clog2(NDR + RD_LAT + 2);
    localparam int unsigned CAP0   = RD_LAT + 1;
    localparam logic [ST_W-1:0] IDLE = ST_W'(IDLE_V);

    logic [ST_W-1:0]    st, st_nxt;
    logic               in_frame, in_frame_nxt;
    logic [14:0]        mem_addr_q, mem_addr_nxt;
    logic [14:0]        slot_addr;
    logic [NDR*8-1:0]   drv_data_q, drv_data_nxt;
    logic [NDR-1:0]     drv_valid_q, drv_valid_nxt;
    logic               frame_done_q, frame_done_nxt;
    logic [1:0]         rom_sz_q, rom_sz_nxt;
    logic               empty8k_q, empty8k_nxt;
    logic               wr_data;

    // Next-state for slot counter, captures, address and ROM size detection
    always_comb begin
        st_nxt         = st;
        in_frame_nxt   = in_frame;
        mem_addr_nxt   = mem_addr_q;
        slot_addr      = '0;
        drv_data_nxt   = drv_data_q;
        drv_valid_nxt  = '0;
        frame_done_nxt = 1'b0;
        rom_sz_nxt     = rom_sz_q;
        empty8k_nxt    = empty8k_q;
        wr_data        = bus.rom_wr && (bus.rom_wdata != 8'h00) && (bus.rom_wdata != 8'hFF);

        if (bus.ph2_f) begin
            st_nxt       = '0;
            in_frame_nxt = 1'b1;
        end else if (st != IDLE) begin
            st_nxt = st + ST_W'(1);
        end else begin
            in_frame_nxt = 1'b0;
        end

        // a frame completes once per ph2_f, on the first clock spent in IDLE
        frame_done_nxt = in_frame && (st == IDLE);

        for (int i = 0; i < int'(NDR); i++) begin
            if (32'(st) == 32'(i))
                slot_addr = bus.drv_addr[i*15 +: 15];
        end
        if (32'(st) < NDR)
            mem_addr_nxt = {slot_addr[14] & rom_sz_q[1],
                            slot_addr[13] & (rom_sz_q[0] | bus.stdrom),
                            slot_addr[12:0]};

        // a new frame strobe pre-empts a capture landing in the same clock
        for (int i = 0; i < int'(NDR); i++) begin
            if (!bus.ph2_f && (32'(st) == 32'(i) + CAP0)) begin
                drv_data_nxt[i*8 +: 8] = bus.mem_q;
                drv_valid_nxt[i]       = 1'b1;
            end
        end

        // rom_sz holds {b32, b32|b16}; non-fill bytes reveal the image size
        if (wr_data)
            rom_sz_nxt = {bus.rom_waddr[14], bus.rom_waddr[14] | bus.rom_waddr[13]};
        if (bus.rom_wr && (bus.rom_waddr == 15'h0000))
            empty8k_nxt = 1'b1;
        if (wr_data && (bus.rom_waddr[14:8] != 7'h00) && (bus.rom_waddr[14:13] == 2'b00))
            empty8k_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            in_frame     <= 1'b0;
            mem_addr_q   <= '0;
            drv_data_q   <= '1;
            drv_valid_q  <= '0;
            frame_done_q <= 1'b0;
            rom_sz_q     <= 2'b11;
            empty8k_q    <= 1'b1;
        end else begin
            st           <= st_nxt;
            in_frame     <= in_frame_nxt;
            mem_addr_q   <= mem_addr_nxt;
            drv_data_q   <= drv_data_nxt;
            drv_valid_q  <= drv_valid_nxt;
            frame_done_q <= frame_done_nxt;
            rom_sz_q     <= rom_sz_nxt;
            empty8k_q    <= empty8k_nxt;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.drv_data   = drv_data_q;
    assign bus.drv_valid  = drv_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.rom_sz     = rom_sz_q;
    assign bus.empty8k    = empty8k_q;

endmodule

// File: tb/tb_iecdrv_rom_arb.sv
// Bench for iecdrv_rom_arb: ROM-size table, frame timing sequences, and random
// frame/abort/reset traffic against an event-schedule reference model.
module tb_iecdrv_rom_arb;
    localparam int NDR = 4;
    localparam int RDL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iecdrv_rom_arb_if #(.NDR(4)) bus ();
    iecdrv_rom_arb #(.NDR(4), .RD_LAT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    iecdrv_rom_arb_if #(.NDR(1)) bus1 ();
    iecdrv_rom_arb #(.NDR(1), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // shared ROM models: q = addr[7:0], RD_LAT register stages behind mem_addr
    logic [7:0] pipe0, pipe1, pipe_b;
    always @(posedge clk) begin
        pipe0  <= bus.mem_addr[7:0];
        pipe1  <= pipe0;
        pipe_b <= bus1.mem_addr[7:0];
    end
    assign bus.mem_q  = pipe1;
    assign bus1.mem_q = pipe_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: pending events scheduled by cycle number
    typedef struct {
        int         at;
        int         kind;   // 0 address slot, 1 capture, 2 frame done
        int         idx;
        logic [7:0] val;
    } ev_t;

    ev_t        evq[$];
    bit         model_on = 1'b0;
    logic [7:0] exp_data [NDR];
    logic [3:0] exp_valid;
    logic       exp_fd;
    logic [14:0] exp_mem;
    logic [1:0] model_sz;

    function automatic logic [14:0] mask_addr(input logic [14:0] a, input logic [1:0] sz, input logic std);
        return {a[14] & sz[1], a[13] & (sz[0] | std), a[12:0]};
    endfunction

    task automatic model_edge();
        ev_t keep[$];
        logic [14:0] a;
        exp_valid = '0;
        exp_fd    = 1'b0;
        if (reset) begin
            evq.delete();
            for (int i = 0; i < NDR; i++) exp_data[i] = 8'hFF;
            exp_mem  = '0;
            model_sz = 2'b11;
            return;
        end
        if (bus.ph2_f) begin
            keep = {};
            foreach (evq[i])
                if ((evq[i].kind == 1) ? (evq[i].at < cyc) : (evq[i].at <= cyc))
                    keep.push_back(evq[i]);
            evq = keep;
        end
        keep = {};
        foreach (evq[i]) begin
            if (evq[i].at == cyc) begin
                case (evq[i].kind)
                    0: begin
                        a = bus.drv_addr[evq[i].idx*15 +: 15];
                        exp_mem = mask_addr(a, model_sz, bus.stdrom);
                    end
                    1: begin
                        exp_data[evq[i].idx]  = evq[i].val;
                        exp_valid[evq[i].idx] = 1'b1;
                    end
                    default: exp_fd = 1'b1;
                endcase
            end else if (evq[i].at > cyc) begin
                keep.push_back(evq[i]);
            end
        end
        evq = keep;
        if (bus.ph2_f) begin
            for (int s = 0; s < NDR; s++) begin
                a = bus.drv_addr[s*15 +: 15];
                evq.push_back('{cyc + 1 + s, 0, s, 8'h00});
                evq.push_back('{cyc + s + RDL + 2, 1, s, a[7:0]});
            end
            evq.push_back('{cyc + NDR + RDL + 2, 2, 0, 8'h00});
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (model_on) model_edge();
    endtask

    task automatic rom_write(input logic [14:0] addr, input logic [7:0] data);
        bus.rom_wr    = 1'b1;
        bus.rom_waddr = addr;
        bus.rom_wdata = data;
        step();
        bus.rom_wr = 1'b0;
    endtask

    // one frame on drive 0 address a, then check the registered slot-0 address
    task automatic mask_probe(input string name, input logic [14:0] a, input logic std, input logic [14:0] exp);
        bus.drv_addr[14:0] = a;
        bus.stdrom = std;
        bus.ph2_f  = 1'b1;
        step();
        bus.ph2_f = 1'b0;
        step();
        check(name, bus.mem_addr, exp);
        for (int k = 0; k < 8; k++) step();
    endtask

    // ph2_f at edge 0, optional second ph2_f at edge p; bytes held at edge hold_k
    task automatic frame_seq(input string name, input int p, input int last,
                             input int hold_k, input logic [31:0] hold_data);
        logic [3:0] ev;
        logic       efd;
        bus.ph2_f = 1'b1;
        step();
        bus.ph2_f = 1'b0;
        for (int k = 1; k <= last; k++) begin
            if (k == p) bus.ph2_f = 1'b1;
            step();
            bus.ph2_f = 1'b0;
            ev  = (k >= p + 4 && k <= p + 7) ? 4'(1 << (k - p - 4)) : 4'b0000;
            efd = (k == p + 8);
            check(name, {bus.drv_valid, bus.frame_done}, {ev, efd});
            if (k == hold_k) check({name, "_hold"}, bus.drv_data, hold_data);
        end
    endtask

    typedef struct {
        logic [14:0] waddr;
        logic [7:0]  wdata;
        logic [1:0]  sz;
        logic        e8k;
    } rom_vec_t;

    rom_vec_t   tbl [10];
    logic [31:0] exp_pack;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{15'h0000, 8'h12, 2'b00, 1'b1};
        tbl[1] = '{15'h0100, 8'h34, 2'b00, 1'b0};
        tbl[2] = '{15'h0200, 8'hFF, 2'b00, 1'b0};
        tbl[3] = '{15'h0000, 8'hFF, 2'b00, 1'b1};
        tbl[4] = '{15'h2000, 8'h55, 2'b01, 1'b1};
        tbl[5] = '{15'h6000, 8'h00, 2'b01, 1'b1};
        tbl[6] = '{15'h4000, 8'h77, 2'b11, 1'b1};
        tbl[7] = '{15'h1FFF, 8'h01, 2'b00, 1'b0};
        tbl[8] = '{15'h00FF, 8'h02, 2'b00, 1'b0};
        tbl[9] = '{15'h6000, 8'h80, 2'b11, 1'b0};

        reset = 1'b1;
        bus.ph2_f = 1'b0; bus.stdrom = 1'b0; bus.drv_addr = '0;
        bus.rom_wr = 1'b0; bus.rom_waddr = '0; bus.rom_wdata = '0;
        bus1.ph2_f = 1'b0; bus1.stdrom = 1'b0; bus1.drv_addr = '0;
        bus1.rom_wr = 1'b0; bus1.rom_waddr = '0; bus1.rom_wdata = '0;
        step();
        step();
        check("rst_rom_sz", bus.rom_sz, 2'b11);
        check("rst_empty8k", bus.empty8k, 1'b1);
        check("rst_mem_addr", bus.mem_addr, 15'h0000);
        check("rst_drv_data", bus.drv_data, 32'hFFFF_FFFF);
        check("rst_valid_fd", {bus.drv_valid, bus.frame_done}, 5'b0);
        check("rst_dut1_data", bus1.drv_data, 8'hFF);
        reset = 1'b0;
        step();
        check("idle_after_rst", {bus.drv_valid, bus.frame_done, bus.mem_addr}, 20'h0);

        foreach (tbl[i]) begin
            rom_write(tbl[i].waddr, tbl[i].wdata);
            check($sformatf("tbl%0d_rom_sz", i), bus.rom_sz, tbl[i].sz);
            check($sformatf("tbl%0d_empty8k", i), bus.empty8k, tbl[i].e8k);
        end

        rom_write(15'h2000, 8'h55);
        check("sz16_rom_sz", bus.rom_sz, 2'b01);
        mask_probe("mask_sz16", 15'h6ABC, 1'b0, 15'h2ABC);
        rom_write(15'h0005, 8'h12);
        check("sz8_rom_sz", bus.rom_sz, 2'b00);
        mask_probe("mask_sz8_std", 15'h6ABC, 1'b1, 15'h2ABC);
        mask_probe("mask_sz8", 15'h6ABC, 1'b0, 15'h0ABC);
        rom_write(15'h4000, 8'h77);
        mask_probe("mask_sz32", 15'h6ABC, 1'b0, 15'h6ABC);

        reset = 1'b1; step(); reset = 1'b0;
        bus.drv_addr = {15'h0043, 15'h0032, 15'h0021, 15'h0010};
        frame_seq("frame", 0, 10, 0, 32'h0);
        check("frame_data", bus.drv_data, 32'h4332_2110);

        bus.drv_addr = {15'h0008, 15'h0077, 15'h0066, 15'h0055};
        frame_seq("abort", 3, 12, 3, 32'h4332_2110);
        check("abort_data", bus.drv_data, 32'h0877_6655);

        bus.drv_addr = {15'h000D, 15'h000C, 15'h000B, 15'h000A};
        frame_seq("prio", 4, 13, 4, 32'h0877_6655);
        check("prio_data", bus.drv_data, 32'h0D0C_0B0A);

        bus.ph2_f = 1'b1; step(); bus.ph2_f = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        reset = 1'b1; step(); reset = 1'b0;
        check("midrst_data", bus.drv_data, 32'hFFFF_FFFF);
        for (int k = 0; k < 10; k++) begin
            step();
            check("midrst_quiet", {bus.drv_valid, bus.frame_done, bus.mem_addr}, 20'h0);
        end

        bus1.drv_addr = 15'h1234;
        bus1.ph2_f = 1'b1; step(); bus1.ph2_f = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("dut1_frame", {bus1.drv_valid, bus1.frame_done}, {k == 3, k == 4});
        end
        check("dut1_data", bus1.drv_data, 8'h34);

        model_on = 1'b1;
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 149) == 0);
            bus.ph2_f  = ($urandom_range(0, 6) == 0);
            bus.stdrom = 1'($urandom);
            if (bus.ph2_f)
                for (int s = 0; s < NDR; s++) bus.drv_addr[s*15 +: 15] = 15'($urandom);
            step();
            for (int s = 0; s < NDR; s++) exp_pack[s*8 +: 8] = exp_data[s];
            check("rnd_valid", bus.drv_valid, exp_valid);
            check("rnd_frame_done", bus.frame_done, exp_fd);
            check("rnd_drv_data", bus.drv_data, exp_pack);
            check("rnd_mem_addr", bus.mem_addr, exp_mem);
        end
        reset = 1'b0;
        bus.ph2_f = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
